parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
- Serial frame receiver. Checks parity using XOR accumulation.
- It is the receiving end of the team's XOR-parity serial link.
- Each frame is: start bit (0), DATA_W data bits sent LSB-first, one parity bit, stop bit (1).
- Bit timing comes from an external one-cycle strobe. The block does no oversampling.
- Received words, with their error flags, are presented on a valid/ready output register.

Parameters:
- DATA_W, 8, number of data bits per frame (valid range 1..16).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  one-cycle strobe marking the sample point of each serial bit.
- rx_in  input  1  serial line. Idles high. Sampled only when bit_en=1.
- data_out  output  DATA_W  received data word.
- valid  output  1  data_out, par_err and frame_err hold a received frame.
- ready  input  1  consumer accepts the word on the cycle where valid&ready=1.
- par_err  output  1  parity mismatch in the held frame.
- frame_err  output  1  stop bit sampled as 0 in the held frame.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the output register was occupied.

Behaviour:
- Reset: when rst=1 at a clock edge, the following happen in that edge:
  - FSM goes to IDLE.
  - Shift register, bit counter and parity accumulator clear to 0.
  - data_out=0, valid=0, par_err=0, frame_err=0, overrun=0.
  - Reset mid-frame discards the partial frame. A held, unaccepted word is also discarded.
- FSM states and transitions (every transition requires bit_en=1, otherwise the state holds):
  - IDLE: rx_in=0 → DATA, with counter=0 and accumulator=0. rx_in=1 → stay in IDLE.
  - DATA: shift rx_in in at the MSB side (right shift), so the first bit ends up in bit 0. Accumulator ^= rx_in, counter += 1. After the DATA_W-th bit → PARITY.
  - PARITY: accumulator ^= rx_in → STOP.
  - STOP: frame complete. Error flags for this frame:
    - parity error = (accumulator != PARITY_ODD).
    - frame error = (rx_in == 0).
    - Then → IDLE.
- Completion handling, on the STOP-state bit_en edge:
  - Output empty (valid=0), or valid&ready=1 in the same cycle: load data_out, par_err and frame_err. valid=1 from the next cycle.
  - Output occupied and not accepted: the new frame is dropped, the old word and flags are kept, and overrun=1 for exactly one cycle.
- Latency: valid rises the cycle after the stop-bit strobe.
- Handshake:
  - valid stays high, and data_out/par_err/frame_err stay stable, until a cycle with valid&ready=1. valid falls after that cycle unless a new frame loads in the same cycle.
  - ready while valid=0 has no effect.
- A frame with frame_err=1 still loads data_out.
- The FSM returns to IDLE regardless of errors. A line held low re-triggers a start on the next bit_en.
- bit_en on consecutive cycles is legal. Each strobe consumes exactly one bit.
- The rx_in value is ignored whenever bit_en=0.
- DATA_W=1 is legal: DATA lasts one strobe.

Test Plan:
- Even parity, DATA_W=8, frame 0xA5:
  - Stimulus: serial bits 0, 1,0,1,0,0,1,0,1, 0, 1 on successive bit_en strobes, with ready=0.
  - Response: after the last strobe, valid=1, data_out=0xA5, par_err=0, frame_err=0. valid is held until ready=1 for one cycle, then drops.
- Same frame with parity bit 1 → data_out=0xA5, par_err=1, frame_err=0.
- Same frame with stop bit 0 → data_out=0xA5, frame_err=1. Line then returned high; a following good 0x3C frame is received with no errors.
- PARITY_ODD=1, frame 0x07 with parity bit 0 → par_err=0. Same frame with parity bit 1 → par_err=1.
- Overrun:
  - Stimulus: two back-to-back frames, 0x11 then 0x22, with ready=0 throughout.
  - Response: data_out stays 0x11 and overrun pulses for 1 cycle at the second stop strobe. Repeating the test with ready=1 exactly on the second stop strobe → data_out=0x22, valid stays 1, no overrun.
- Reset mid-frame: assert rst after 4 data bits of 0xFF → all outputs 0. A following full 0x5A frame is received correctly. bit_en pulses with rx_in=1 while in IDLE produce no valid.

Source files
------------

// File: rtl/parity_frame_rx.sv
// Receiving end of the XOR-parity serial link: start bit, LSB-first data, parity, stop.
// Bit timing comes from an external strobe; finished words sit in a valid/ready output register.
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic              par_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par_err;
        logic              frame_err;
    } rsp_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              acc, acc_nxt;
    logic              frame_done;
    rsp_t              frame_rsp;
    rsp_t              rsp, rsp_nxt;
    logic              valid_q, valid_nxt;
    logic              ovr_q, ovr_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        frame_done = 1'b0;

        frame_rsp.data      = shreg;
        frame_rsp.par_err   = (acc != PARITY_ODD);
        frame_rsp.frame_err = ~rx_in;

        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        acc_nxt   = 1'b0;
                    end
                end
                DATA: begin
                    // Shift in at the MSB so the first (LSB) bit lands in bit 0.
                    shreg_nxt             = shreg >> 1;
                    shreg_nxt[DATA_W-1]   = rx_in;
                    acc_nxt               = acc ^ rx_in;
                    cnt_nxt               = cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) state_nxt = PARITY;
                end
                PARITY: begin
                    acc_nxt   = acc ^ rx_in;
                    state_nxt = STOP;
                end
                STOP: begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A completed frame may load into a slot that is being drained in the same cycle.
    always_comb begin
        rsp_nxt   = rsp;
        valid_nxt = valid_q;
        ovr_nxt   = 1'b0;

        if (valid_q && ready) valid_nxt = 1'b0;

        if (frame_done) begin
            if (!valid_q || ready) begin
                rsp_nxt   = frame_rsp;
                valid_nxt = 1'b1;
            end else begin
                ovr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            acc     <= 1'b0;
            rsp     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            rsp     <= rsp_nxt;
            valid_q <= valid_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    assign data_out  = rsp.data;
    assign par_err   = rsp.par_err;
    assign frame_err = rsp.frame_err;
    assign valid     = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: an even- and an odd-parity receiver share one line;
// a frame-level reference model predicts words, flags, valid occupancy and overrun pulses.
module tb_parity_frame_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, bit_en, rx_in, ready;
    logic [DW-1:0] d0, d1;
    logic          v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx_in(rx_in),
        .data_out(d0), .valid(v0), .ready(ready),
        .par_err(pe0), .frame_err(fe0), .overrun(ov0)
    );

    parity_frame_rx #(.DATA_W(DW), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx_in(rx_in),
        .data_out(d1), .valid(v1), .ready(ready),
        .par_err(pe1), .frame_err(fe1), .overrun(ov1)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          pe_even;
        logic          pe_odd;
        logic          fe;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: gathers the bits after a start bit, then applies the
    // one-deep output slot rules at frame level.
    bit      hold = 1'b0;
    bit      exp_ovr = 1'b0;
    bit      in_frame = 1'b0;
    bit      m_done;
    logic    bits[$];
    logic [DW-1:0] m_w;
    int      m_ones;
    exp_t    m_e;

    always @(posedge clk) begin
        exp_ovr = 1'b0;
        m_done  = 1'b0;
        if (rst) begin
            hold     = 1'b0;
            in_frame = 1'b0;
            bits.delete();
            q.delete();
        end else begin
            if (bit_en) begin
                if (!in_frame) begin
                    if (rx_in == 1'b0) begin
                        in_frame = 1'b1;
                        bits.delete();
                    end
                end else begin
                    bits.push_back(rx_in);
                    if (bits.size() == DW + 2) begin
                        for (int i = 0; i < DW; i++) m_w[i] = bits[i];
                        m_ones      = $countones(m_w) + int'(bits[DW]);
                        m_e.data    = m_w;
                        m_e.pe_even = (m_ones % 2) != 0;
                        m_e.pe_odd  = (m_ones % 2) != 1;
                        m_e.fe      = (bits[DW+1] == 1'b0);
                        m_done      = 1'b1;
                        in_frame    = 1'b0;
                    end
                end
            end
            if (m_done) begin
                if (!hold || ready) begin
                    q.push_back(m_e);
                    hold = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (hold && ready) begin
                hold = 1'b0;
            end
        end
    end

    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_even", v0, hold);
            chk("valid_odd", v1, hold);
            chk("overrun_even", ov0, exp_ovr);
            chk("overrun_odd", ov1, exp_ovr);
            if (v0 && ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", d0, $time);
                end else begin
                    mon_e = q.pop_front();
                    chk("data_even", d0, mon_e.data);
                    chk("data_odd", d1, mon_e.data);
                    chk("par_err_even", pe0, mon_e.pe_even);
                    chk("par_err_odd", pe1, mon_e.pe_odd);
                    chk("frame_err_even", fe0, mon_e.fe);
                    chk("frame_err_odd", fe1, mon_e.fe);
                end
            end
        end
    end

    task automatic cyc(input logic be, input logic rx, input logic rd);
        bit_en = be;
        rx_in  = rx;
        ready  = rd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input int m);
        if (m == 0) return 1'b0;
        if (m == 1) return 1'b1;
        return logic'($urandom_range(0, 1));
    endfunction

    // rm: ready during the frame (0 low, 1 high, 2 random); rd_stop: ready on the stop strobe.
    task automatic frame(input logic [DW-1:0] d, input logic pb, input logic sb,
                         input int rm, input logic rd_stop, input int maxgap);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < DW; i++) fb.push_back(d[i]);
        fb.push_back(pb);
        fb.push_back(sb);
        for (int i = 0; i < fb.size(); i++) begin
            int g;
            g = $urandom_range(0, maxgap);
            repeat (g) cyc(1'b0, logic'($urandom_range(0, 1)), rdy_of(rm));
            cyc(1'b1, fb[i], (i == fb.size() - 1) ? rd_stop : rdy_of(rm));
        end
    endtask

    task automatic drain();
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, {d1, d0}, 0);
        chk({tag, "_valid"}, {v1, v0}, 0);
        chk({tag, "_par_err"}, {pe1, pe0}, 0);
        chk({tag, "_frame_err"}, {fe1, fe0}, 0);
        chk({tag, "_overrun"}, {ov1, ov0}, 0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          pb, sb;
        rst = 1'b1; bit_en = 1'b0; rx_in = 1'b1; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;

        // 0xA5 good even parity, held with ready low, then accepted.
        frame(8'hA5, ^8'hA5, 1'b1, 0, 1'b0, 0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        drain();
        frame(8'hA5, 1'b1, 1'b1, 0, 1'b0, 1);
        drain();
        // Bad stop bit, line returned high, then a clean 0x3C.
        frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 0);
        drain();
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        frame(8'h3C, ^8'h3C, 1'b1, 0, 1'b0, 0);
        drain();
        frame(8'h07, 1'b0, 1'b1, 0, 1'b0, 0);
        drain();
        frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 0);
        drain();

        // Overrun, then the same pair with ready on the second stop strobe.
        frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 0);
        frame(8'h22, 1'b0, 1'b1, 0, 1'b0, 0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        drain();
        frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 0);
        frame(8'h22, 1'b0, 1'b1, 0, 1'b1, 0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        drain();

        // Reset with a held word and a partial frame in flight.
        frame(8'h81, 1'b0, 1'b1, 0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk); #1;
        frame(8'h5A, ^8'h5A, 1'b1, 0, 1'b0, 0);
        drain();
        repeat (6) cyc(1'b1, 1'b1, 1'b1);

        // Randomized traffic: data, parity, stop, ready and strobe spacing.
        for (int n = 0; n < 200; n++) begin
            rd = DW'($urandom());
            pb = ($urandom_range(0, 9) < 7) ? ^rd : ~^rd;
            sb = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b1, rdy_of(2));
            frame(rd, pb, sb, $urandom_range(0, 2), logic'($urandom_range(0, 1)),
                  $urandom_range(0, 2));
        end

        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
